// File: rtl/nv_ram_rwsp_gen.sv
// ---------------------------------------------------------------------------
// nv_ram_rwsp_gen
// Parametrised single-clock RAM with one read port and one write port.
//   - read address is registered (address stage, 're')
//   - read data is registered (data stage, 'ore')
//   - per-bit write mask
//   - after reset a sequencer writes INIT_VAL into every entry; 'init_done'
//     tells the upstream client when traffic is accepted
//   - 'coll' pulses one cycle after a same-edge write / data-stage read of
//     the same in-range address
//
// Optional feature macro: NV_RAM_RWSP_GEN_BYPASS_EN
//   defined   : a colliding data stage loads the freshly merged write word
//   undefined : a colliding data stage loads the old memory word
// ---------------------------------------------------------------------------
module nv_ram_rwsp_gen #(
    parameter int             DEPTH    = 16,
    parameter int             AW       = 4,
    parameter int             DW       = 65,
    parameter logic [DW-1:0]  INIT_VAL = {DW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     ra,
    input  logic              re,
    input  logic              ore,
    output logic [DW-1:0]     dout,
    output logic              dout_vld,
    input  logic [AW-1:0]     wa,
    input  logic              we,
    input  logic [DW-1:0]     di,
    input  logic [DW-1:0]     wmask,
    output logic              init_done,
    output logic              coll,
    input  logic [31:0]       pwrbus_ram_pd
);

    // Depth expressed one bit wider than an address so that "addr < DEPTH"
    // is a plain unsigned compare, also when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] ZERO_D   = {DW{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit-masked merge: mask bit 1 takes the new bit, 0 keeps the old one.
    function automatic logic [DW-1:0] f_merge(
        input logic [DW-1:0] new_d,
        input logic [DW-1:0] old_d,
        input logic [DW-1:0] mask
    );
        return (new_d & mask) | (old_d & ~mask);
    endfunction

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [DW-1:0] r_mem [DEPTH];

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_init_cnt;
    logic          r_init_done;

    logic [AW-1:0] r_ra_d;
    logic          r_rd_pend;
    logic [DW-1:0] r_dout;
    logic          r_dout_vld;
    logic          r_coll;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          w_run;
    logic          w_wa_ok;
    logic          w_rd_ok;
    logic [DW-1:0] w_rdata_old;
    logic [DW-1:0] w_wdata_old;
    logic [DW-1:0] w_wdata_merged;
    logic          w_coll;
    logic [DW-1:0] w_dout_nxt;

    logic          w_mem_we;
    logic [AW-1:0] w_mem_wa;
    logic [DW-1:0] w_mem_wd;

    // The power-down bus has no functional effect; fold it so it is consumed.
    logic          w_pwrbus_unused;
    assign w_pwrbus_unused = ^pwrbus_ram_pd;

    // Range checks and the two memory read views (data stage and write merge).
    always_comb begin
        w_run   = (r_state == ST_RUN);
        w_wa_ok = ({1'b0, wa}     < DEPTH_W);
        w_rd_ok = ({1'b0, r_ra_d} < DEPTH_W);
        if (w_rd_ok) begin
            w_rdata_old = r_mem[r_ra_d];
        end else begin
            w_rdata_old = ZERO_D;
        end
        if (w_wa_ok) begin
            w_wdata_old = r_mem[wa];
        end else begin
            w_wdata_old = ZERO_D;
        end
        w_wdata_merged = f_merge(di, w_wdata_old, wmask);
    end

    // Collision detect and selection of the word the data stage will load.
    always_comb begin
        w_coll = w_run & we & ore & (wa == r_ra_d) & w_wa_ok;
`ifdef NV_RAM_RWSP_GEN_BYPASS_EN
        if (w_coll) begin
            w_dout_nxt = w_wdata_merged;
        end else begin
            w_dout_nxt = w_rdata_old;
        end
`else
        w_dout_nxt = w_rdata_old;
`endif
    end

    // Write port mux: the init sequencer owns the port until RUN.
    always_comb begin
        w_mem_we = 1'b0;
        w_mem_wa = r_init_cnt;
        w_mem_wd = INIT_VAL;
        if (rst) begin
            w_mem_we = 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_mem_we = 1'b1;
                    w_mem_wa = r_init_cnt;
                    w_mem_wd = INIT_VAL;
                end
                ST_RUN: begin
                    w_mem_we = we & w_wa_ok;
                    w_mem_wa = wa;
                    w_mem_wd = w_wdata_merged;
                end
                default: begin
                    w_mem_we = 1'b0;
                end
            endcase
        end
    end

    // Next-state logic: INIT leaves after the last entry has been written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_INIT;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Init address counter; parks on the last index so it never passes DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_cnt <= {AW{1'b0}};
        end else if ((r_state == ST_INIT) && (r_init_cnt != LAST_IDX)) begin
            r_init_cnt <= r_init_cnt + ONE_A;
        end
    end

    // init_done rises on the edge that writes the last entry and stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_init_done <= 1'b0;
        end else if ((r_state == ST_INIT) && (r_init_cnt == LAST_IDX)) begin
            r_init_done <= 1'b1;
        end
    end

    // Memory array write (no reset: contents are cleared by the sequencer).
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    // Read pipeline and collision flag; frozen at reset values during INIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra_d     <= {AW{1'b0}};
            r_rd_pend  <= 1'b0;
            r_dout     <= ZERO_D;
            r_dout_vld <= 1'b0;
            r_coll     <= 1'b0;
        end else if (w_run) begin
            if (re) begin
                r_ra_d <= ra;
            end
            // The data stage consumes the pending request seen before this edge;
            // a request arriving on the same edge stays pending.
            r_rd_pend <= re | (r_rd_pend & ~ore);
            if (ore) begin
                r_dout     <= w_dout_nxt;
                r_dout_vld <= r_rd_pend;
            end
            r_coll <= w_coll;
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign init_done = r_init_done;
    assign coll      = r_coll;

endmodule

// File: tb/tb_nv_ram_rwsp_gen.sv
// ---------------------------------------------------------------------------
// Testbench for nv_ram_rwsp_gen.
// Two instances (DEPTH=16 and DEPTH=12, both AW=4) share one stimulus
// stream, so addresses 12..15 exercise the out-of-range rules on the
// smaller one. A reference model computes the expected registered outputs
// of each instance per clock edge; the expectations are queued by the
// stimulus process and popped/compared by an independent monitor.
// ---------------------------------------------------------------------------
module tb_nv_ram_rwsp_gen;

    localparam int             DW     = 65;
    localparam int             AW     = 4;
    localparam logic [DW-1:0]  INIT_V = 65'h1_2345_6789_ABCD_EF01;
    localparam logic [DW-1:0]  ONES   = {DW{1'b1}};
    localparam logic [DW-1:0]  ZEROS  = {DW{1'b0}};
`ifdef NV_RAM_RWSP_GEN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] ra  = 4'd0;
    logic          re  = 1'b0;
    logic          ore = 1'b0;
    logic [AW-1:0] wa  = 4'd0;
    logic          we  = 1'b0;
    logic [DW-1:0] di  = ZEROS;
    logic [DW-1:0] wmask = ZEROS;
    logic [31:0]   pwr = 32'h0;

    logic [DW-1:0] dout16, dout12;
    logic          vld16, vld12, coll16, coll12, done16, done12;

    always #5 clk = ~clk;

    nv_ram_rwsp_gen #(.DEPTH(16), .AW(AW), .DW(DW), .INIT_VAL(INIT_V)) u_dut16 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore),
        .dout(dout16), .dout_vld(vld16), .wa(wa), .we(we), .di(di),
        .wmask(wmask), .init_done(done16), .coll(coll16), .pwrbus_ram_pd(pwr)
    );

    nv_ram_rwsp_gen #(.DEPTH(12), .AW(AW), .DW(DW), .INIT_VAL(INIT_V)) u_dut12 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .ore(ore),
        .dout(dout12), .dout_vld(vld12), .wa(wa), .we(we), .di(di),
        .wmask(wmask), .init_done(done12), .coll(coll12), .pwrbus_ram_pd(pwr)
    );

    typedef struct packed {
        logic [DW-1:0] dout;
        logic          vld;
        logic          coll;
        logic          done;
    } exp_t;

    exp_t q16[$];
    exp_t q12[$];

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = DEPTH 16, index 1 = DEPTH 12.
    int            dep [2] = '{16, 12};
    logic [DW-1:0] m_mem [2][16];
    int            m_cnt  [2];
    bit            m_pend [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_dout [2];
    bit            m_vld  [2];
    bit            m_coll [2];
    bit            m_done [2];

    // One clock edge of the behavioural model for instance k.
    task automatic model_edge(input int k, input logic r, input logic w,
                              input logic [AW-1:0] a_w, input logic [DW-1:0] d,
                              input logic [DW-1:0] m, input logic rr,
                              input logic [AW-1:0] a_r, input logic o);
        int            dd;
        logic [DW-1:0] old_w;
        logic [DW-1:0] mrg;
        bit            c;
        dd = dep[k];
        if (r) begin
            m_cnt[k] = 0; m_pend[k] = 0; m_addr[k] = 4'd0;
            m_dout[k] = ZEROS; m_vld[k] = 0; m_coll[k] = 0; m_done[k] = 0;
        end else if (m_cnt[k] < dd) begin
            m_mem[k][m_cnt[k]] = INIT_V;
            m_cnt[k] = m_cnt[k] + 1;
            m_done[k] = (m_cnt[k] == dd);
        end else begin
            old_w = (int'(m_addr[k]) < dd) ? m_mem[k][m_addr[k]] : ZEROS;
            mrg   = (int'(a_w) < dd) ? ((d & m) | (m_mem[k][a_w] & ~m)) : ZEROS;
            c     = w && o && (a_w == m_addr[k]) && (int'(a_w) < dd);
            if (o) begin
                m_dout[k] = (BYP && c) ? mrg : old_w;
                m_vld[k]  = m_pend[k];
            end
            if (w && (int'(a_w) < dd)) m_mem[k][a_w] = mrg;
            m_pend[k] = rr || (m_pend[k] && !o);
            if (rr) m_addr[k] = a_r;
            m_coll[k] = c;
        end
    endtask

    // Drive one cycle of inputs and queue the expected post-edge outputs.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] a_w,
                        input logic [DW-1:0] d, input logic [DW-1:0] m,
                        input logic rr, input logic [AW-1:0] a_r, input logic o);
        @(negedge clk);
        rst = r; we = w; wa = a_w; di = d; wmask = m; re = rr; ra = a_r; ore = o;
        pwr = $urandom;
        for (int k = 0; k < 2; k++) model_edge(k, r, w, a_w, d, m, rr, a_r, o);
        q16.push_back('{m_dout[0], m_vld[0], m_coll[0], m_done[0]});
        q12.push_back('{m_dout[1], m_vld[1], m_coll[1], m_done[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        step(1'b0, 1'b1, a, d, m, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, a, 1'b0);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b1);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
        checks = checks + 1;
        if (act !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: after every active edge, pop the expectation for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q16.size() > 0) begin
                e = q16.pop_front();
                chk("d16_dout", dout16, e.dout);
                chk("d16_vld",  {64'd0, vld16},  {64'd0, e.vld});
                chk("d16_coll", {64'd0, coll16}, {64'd0, e.coll});
                chk("d16_done", {64'd0, done16}, {64'd0, e.done});
            end
            if (q12.size() > 0) begin
                e = q12.pop_front();
                chk("d12_dout", dout12, e.dout);
                chk("d12_vld",  {64'd0, vld12},  {64'd0, e.vld});
                chk("d12_coll", {64'd0, coll12}, {64'd0, e.coll});
                chk("d12_done", {64'd0, done12}, {64'd0, e.done});
            end
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic          r_s, w_s, rr_s, o_s;
        logic [AW-1:0] aw_s, ar_s;
        logic [DW-1:0] m_s;

        // Reset pulse, then init with garbage traffic that must be ignored.
        step(1'b1, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), rnd_word(), ONES,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        idle(4);

        // Read back every entry with pipelined re/ore.
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'd0, 1'b0);
        for (int i = 1; i < 16; i++) step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'(i), 1'b1);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b1);

        // Latency and hold.
        wr(4'd5, 65'h0_DEAD_BEEF, ONES);
        rd(4'd5);
        idle(10);

        // Masked write.
        wr(4'd3, ONES, ONES);
        wr(4'd3, ZEROS, 65'h0_0000_FFFF);
        rd(4'd3);

        // Collision.
        wr(4'd7, 65'hA, ONES);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 65'hB, ONES, 1'b0, 4'd0, 1'b1);
        idle(1);
        rd(4'd7);

        // Pending/valid: ore with nothing pending, then overlapping requests.
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b1);
        wr(4'd1, 65'h111, ONES);
        wr(4'd2, 65'h222, ONES);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'd2, 1'b1);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b1);

        // Mid-run reset, re-init, and out-of-range access.
        wr(4'd9, 65'h5, ONES);
        step(1'b0, 1'b0, 4'd0, ZEROS, ZEROS, 1'b1, 4'd9, 1'b0);
        step(1'b1, 1'b0, 4'd0, ZEROS, ZEROS, 1'b0, 4'd0, 1'b1);
        idle(16);
        rd(4'd9);
        wr(4'd13, 65'h1_3131_3131, ONES);
        rd(4'd13);
        idle(2);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            r_s  = ($urandom_range(0, 249) == 0);
            w_s  = 1'($urandom_range(0, 1));
            rr_s = 1'($urandom_range(0, 1));
            o_s  = 1'($urandom_range(0, 1));
            ar_s = 4'($urandom_range(0, 15));
            aw_s = ($urandom_range(0, 2) == 0) ? ar_s : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 2))
                0:       m_s = ONES;
                1:       m_s = rnd_word();
                default: m_s = ZEROS;
            endcase
            step(r_s, w_s, aw_s, rnd_word(), m_s, rr_s, ar_s, o_s);
        end
        idle(2);

        repeat (2) @(posedge clk);
        #5;
        checks = checks + 1;
        if ((q16.size() != 0) || (q12.size() != 0)) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d/%0d entries left expected 0", q16.size(), q12.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nv_ram_rwsp_gen.md
# nv_ram_rwsp_gen

Parametrised single-clock, two-port (one read, one write) RAM with a registered read address, a registered output stage, a bit-masked write and a hardware init sequencer. It clears every entry after reset and reports read-data validity. It is the generic replacement for the fixed-geometry rwsp RAM instances in NVDLA datapath buffers. `init_done` gates the upstream client.

## Interface
- `DEPTH`, default 16: number of entries; ≥2, not necessarily a power of two.
- `AW`, default 4: address width; ≥ ceil(log2(DEPTH)).
- `DW`, default 65: data width.
- `INIT_VAL`, default 0: DW-bit value written to every entry during init.

- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `ra`  in  AW: read address, sampled when `re`=1.
- `re`  in  1: read enable (address stage).
- `ore`  in  1: output register enable (data stage).
- `dout`  out  DW: registered read data.
- `dout_vld`  out  1: `dout` holds data for a request.
- `wa`  in  AW: write address.
- `we`  in  1: write enable.
- `di`  in  DW: write data.
- `wmask`  in  DW: per-bit write mask; 1 = bit written.
- `init_done`  out  1: init sequence complete; RAM accepts traffic.
- `coll`  out  1: registered one-cycle pulse flagging a read/write collision.
- `pwrbus_ram_pd`  in  32: power-down bus; accepted, no functional effect.

## Operation
- FSM states are INIT and RUN. `rst`=1 forces INIT with `init_cnt`=0 and clears `ra_d`, `rd_pend`, `dout`, `dout_vld`, `coll` and `init_done` to 0.
- INIT:
  - Each cycle writes INIT_VAL to M[init_cnt] and increments `init_cnt`.
  - After writing entry DEPTH-1 the FSM moves to RUN.
  - `we`, `re` and `ore` are ignored, and the outputs hold their reset values.
- RUN, `init_done`=1:
  - Write: if `we` and `wa`<DEPTH, then M[wa] <= (di & wmask) | (M[wa] & ~wmask). If `wa`≥DEPTH the write is dropped.
  - Address stage: if `re`, `ra_d` <= `ra` and `rd_pend` <= 1. Otherwise `ra_d` holds.
  - Data stage: `rdata` = M[ra_d], or 0 if `ra_d`≥DEPTH. If `ore`, `dout` <= `rdata` and `dout_vld` <= `rd_pend` (value before update). If `ore`=0, `dout` and `dout_vld` hold.
  - Pending flag: `rd_pend` <= `re` | (`rd_pend` & ~`ore`). A simultaneous `re` and `ore` delivers the older address and leaves the new request pending.
  - Collision: `coll` <= `we` & `ore` & (`wa`==`ra_d`) & (`wa`<DEPTH). Otherwise `coll` <= 0.
- `rst` asserted mid-RUN restarts INIT. All contents are re-initialised and any in-flight read is discarded.
- Arithmetic: `init_cnt` is AW bits wide and is compared against DEPTH-1, so it never wraps past DEPTH. Address comparisons are unsigned.

## Timing
- Init takes exactly DEPTH cycles. With `rst` deasserted at edge 0, `init_done` reads 1 from edge DEPTH.
- Read latency: `re` at edge N and `ore` at edge N+1 give `dout`/`dout_vld` valid after edge N+1, i.e. visible in cycle N+2.
- Write-to-read: data written at edge N is returned by a read whose data stage (`ore`) is at edge N+1 or later.
- A same-edge write and data stage on the same address returns old data (see Configuration).
- `coll` is valid the cycle after the colliding edge.
- `dout` is stable while `ore`=0, for any number of cycles.

## Configuration
- `NV_RAM_RWSP_GEN_BYPASS_EN`:
  - Defined: on a same-edge collision (`we`, `ore`, `wa`==`ra_d`), `dout` loads the merged new word (di & wmask) | (M[wa] & ~wmask).
  - Undefined: `dout` loads the old M[ra_d].
  - `coll` behaves identically in both builds.

## Test plan
- Init: DEPTH=16, INIT_VAL=0x1_2345_6789_ABCD_EF01. Pulse `rst` for 1 cycle → `init_done`=0 for 16 cycles, then 1. Reading entries 0..15 returns INIT_VAL. `we` driven during INIT → no effect.
- Latency/hold: write 0x0_DEAD_BEEF to entry 5; `re` with `ra`=5 at N, `ore` at N+1 → `dout`=0x0_DEAD_BEEF and `dout_vld`=1 at N+2. Hold `ore`=0 for 10 cycles → both unchanged.
- Mask: entry 3 holds all-ones; write di=0 with wmask=0x0_0000_FFFF → read returns 0x1_FFFF_FFFF_FFFF_0000.
- Collision: `ra_d`=7 with M[7]=0xA; `we` to 7 with di=0xB on the same edge as `ore` → `coll`=1 one cycle later. `dout`=0xA without the macro and 0xB with it. A following read returns 0xB in both builds.
- Pending/valid: `ore` without a prior `re` → `dout_vld`=0. Simultaneous `re`(ra=2) and `ore` after a pending `re`(ra=1) → `dout`=M[1] with `dout_vld`=1; the next `ore` gives `dout`=M[2] with `dout_vld`=1.
- Mid-run reset and range: write 0x5 to entry 9, assert `rst` → `dout`/`dout_vld`/`init_done`=0, and entry 9 reads INIT_VAL after init. With DEPTH=12, a write to 13 is dropped and a read of 13 returns 0.
